uart_fifo_core: RTL

- Serial UART engine directly downstream of the AXI-lite UART register adapter; consumes its reg_div_* / reg_dat_* strobes and drives ser_tx / samples ser_rx.
- Buffers TX and RX bytes in FIFOs, so reg_dat_wait asserts only when the TX FIFO is full. Reads return the RX FIFO head, or all-ones when empty.
- Adds a status/W1C-error register.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_fifo_core.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART engine.
// State encodings, status word bit positions and the empty-read value.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_EMPTY  = 2;
  localparam int STAT_RX_FULL   = 3;
  localparam int STAT_OVERRUN   = 4;
  localparam int STAT_FRAME_ERR = 5;
  localparam int STAT_TX_BUSY   = 6;

  localparam logic [31:0] UART_RX_EMPTY = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_DIV       = 32'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is always visible on dout.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/uart_fifo_core.sv
// Buffered UART engine: divider register, TX/RX FIFOs, serial TX/RX state machines
// and a status word with sticky write-one-to-clear error flags.
module uart_fifo_core #(
  parameter logic [31:0] DEFAULT_DIV = 32'd104,
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  input  logic        reg_stat_we,
  input  logic [31:0] reg_stat_di,
  output logic [31:0] reg_stat_do
);
  import uart_pkg::*;

  logic [31:0] div_reg, eff_div;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_dout;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_dout;
  logic [$clog2(RX_DEPTH):0] rx_count;

  tx_state_t   tx_state, tx_state_n;
  logic [31:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;

  rx_state_t   rx_state, rx_state_n;
  logic [31:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_meta, rx_s;
  logic        set_overrun, set_frame_err, overrun, frame_err;
  logic        unused_bits;

  assign unused_bits = ^{reg_dat_di[31:8], reg_stat_di[31:6], reg_stat_di[3:0], tx_count, rx_count};

  // Divider is byte-writable; bit timers reload from it only at bit boundaries.
  always_ff @(posedge clk) begin
    if (reset) div_reg <= DEFAULT_DIV;
    else begin
      for (int i = 0; i < 4; i++)
        if (reg_div_we[i]) div_reg[8*i +: 8] <= reg_div_di[8*i +: 8];
    end
  end

  assign eff_div    = (div_reg < MIN_DIV) ? MIN_DIV : div_reg;
  assign reg_div_do = div_reg;

  assign tx_push      = reg_dat_we && !tx_full;
  assign reg_dat_wait = reg_dat_we && tx_full;
  assign rx_pop       = reg_dat_re && !rx_empty;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .din(reg_dat_di[7:0]), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift_n), .pop(rx_pop),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
    end
  end

  // STOP chains straight into START when another byte is waiting, so frames abut.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_shift_n = tx_dout; tx_cnt_n = eff_div - 32'd1; tx_state_n = TX_START;
      end
      TX_START: if (tx_cnt == '0) begin
        tx_cnt_n = eff_div - 32'd1; tx_bit_n = '0; tx_state_n = TX_DATA;
      end else tx_cnt_n = tx_cnt - 32'd1;
      TX_DATA: if (tx_cnt == '0) begin
        tx_cnt_n = eff_div - 32'd1;
        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
      end else tx_cnt_n = tx_cnt - 32'd1;
      TX_STOP: if (tx_cnt == '0) begin
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_n = tx_dout; tx_cnt_n = eff_div - 32'd1; tx_state_n = TX_START;
        end else tx_state_n = TX_IDLE;
      end else tx_cnt_n = tx_cnt - 32'd1;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign ser_tx = (tx_state == TX_START) ? 1'b0 :
                  (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= ser_rx;
      rx_s     <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Half-bit wait after the falling edge puts every later sample mid-bit.
  always_comb begin
    rx_state_n    = rx_state;
    rx_cnt_n      = rx_cnt;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_push       = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_s) begin
        rx_cnt_n = (eff_div >> 1) - 32'd1; rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == '0) begin
        if (rx_s) rx_state_n = RX_IDLE;
        else begin
          rx_cnt_n = eff_div - 32'd1; rx_bit_n = '0; rx_state_n = RX_DATA;
        end
      end else rx_cnt_n = rx_cnt - 32'd1;
      RX_DATA: if (rx_cnt == '0) begin
        rx_shift_n = {rx_s, rx_shift[7:1]};
        rx_cnt_n   = eff_div - 32'd1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else rx_bit_n = rx_bit + 3'd1;
      end else rx_cnt_n = rx_cnt - 32'd1;
      RX_STOP: if (rx_cnt == '0) begin
        rx_state_n = RX_IDLE;
        if (!rx_s) set_frame_err = 1'b1;
        else if (!rx_full || rx_pop) rx_push = 1'b1;
        else set_overrun = 1'b1;
      end else rx_cnt_n = rx_cnt - 32'd1;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= set_overrun   | (overrun   & ~(reg_stat_we & reg_stat_di[STAT_OVERRUN]));
      frame_err <= set_frame_err | (frame_err & ~(reg_stat_we & reg_stat_di[STAT_FRAME_ERR]));
    end
  end

  assign reg_dat_do = rx_empty ? UART_RX_EMPTY : {24'b0, rx_dout};

  always_comb begin
    reg_stat_do                 = '0;
    reg_stat_do[STAT_TX_FULL]   = tx_full;
    reg_stat_do[STAT_TX_EMPTY]  = tx_empty;
    reg_stat_do[STAT_RX_EMPTY]  = rx_empty;
    reg_stat_do[STAT_RX_FULL]   = rx_full;
    reg_stat_do[STAT_OVERRUN]   = overrun;
    reg_stat_do[STAT_FRAME_ERR] = frame_err;
    reg_stat_do[STAT_TX_BUSY]   = (tx_state != TX_IDLE);
  end

endmodule
